// File: rtl/stream_to_bram_if.sv
// stream_to_bram_if: 32-bit AXI-stream beat handshake.
// master drives data/valid, slave returns ready.
interface stream_to_bram_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;

  modport master (
    output TDATA,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/stream_to_bram.sv
// stream_to_bram: AXI-stream capture sink writing into a BRAM port.
// Optional ring/stop mode: define STREAM_TO_BRAM_RING_EN.
module stream_to_bram #(
  parameter int MEM_DEPTH          = 2048,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_REG              = 4
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            IPIF_Bus2IP_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_Bus2IP_Addr,
  input  logic                            IPIF_Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_Bus2IP_BE,
  input  logic                            IPIF_Bus2IP_CS,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_RdCE,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_WrCE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_IP2Bus_Data,
  output logic                            IPIF_IP2Bus_WrAck,
  output logic                            IPIF_IP2Bus_RdAck,
  output logic                            IPIF_IP2Bus_Error,
  input  logic                            fc_orbitSync,
  output logic                            bram_CLK,
  output logic                            bram_RST,
  output logic                            bram_EN,
  output logic [3:0]                      bram_WE,
  output logic [31:0]                     bram_ADDR,
  output logic [31:0]                     bram_DIN,
  stream_to_bram_if.slave                 data_stream
);

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] count_q, count_d;
  logic        done_q, done_d;
  logic [1:0]  mode_q;
  logic [15:0] len_q;
  logic [16:0] len_eff;
  logic        orbit_q;
  logic        orbit_edge;
  logic        tready_q;
  logic        beat;
  logic        wr_en;
  logic        busy;
  logic        arm;
  logic [1:0]  arm_mode;
  logic [31:0] wd;
  logic [31:0] rd_word;
  logic [31:0] rdata_q;
  logic        wr_ack_q;
  logic        rd_ack_q;
  logic [N_REG-1:0] wr_sel;
  logic [N_REG-1:0] rd_sel;
  logic        unused_ok;

`ifdef STREAM_TO_BRAM_RING_EN
  logic        ring_q;
  logic        stop;
  logic        wrapped_q, wrapped_d;
  logic [15:0] last_q, last_d;
`endif

  for (genvar g = 0; g < N_REG; g++) begin : g_sel
    assign wr_sel[g] = IPIF_Bus2IP_WrCE[N_REG-1-g];
    assign rd_sel[g] = IPIF_Bus2IP_RdCE[N_REG-1-g];
  end

  assign wd       = 32'(IPIF_Bus2IP_Data);
  assign arm      = wr_sel[0] & wd[0];
  assign arm_mode = wd[2:1];
`ifdef STREAM_TO_BRAM_RING_EN
  assign stop     = wr_sel[0] & wd[4];
`endif

  assign unused_ok = ^{IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW,
                       IPIF_Bus2IP_BE, IPIF_Bus2IP_CS,
                       wd[31:16], wd[4:3]};

  assign len_eff = (len_q == 16'd0 || {1'b0, len_q} > DEPTH)
                 ? DEPTH : {1'b0, len_q};

  assign orbit_edge = fc_orbitSync & ~orbit_q;
  assign busy       = (state_q == WAIT_TRIG) | (state_q == CAPTURE);
  assign beat       = data_stream.TVALID & tready_q;

  // Beat is written in CAPTURE, or on the trigger edge itself.
  always_comb begin
    wr_en = beat & ~arm &
            ((state_q == CAPTURE) |
             ((state_q == WAIT_TRIG) & orbit_edge));
`ifdef STREAM_TO_BRAM_RING_EN
    wr_en = wr_en & ~stop;
`endif
  end

  assign data_stream.TREADY = tready_q;
  assign bram_CLK  = clk;
  assign bram_RST  = ~aresetn;
  assign bram_EN   = wr_en;
  assign bram_WE   = {4{wr_en}};
  assign bram_ADDR = {13'b0, count_q, 2'b00};
  assign bram_DIN  = wr_en ? data_stream.TDATA : 32'b0;

  // Register bank; cleared by either reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= 2'd0;
      len_q  <= DEPTH[15:0];
`ifdef STREAM_TO_BRAM_RING_EN
      ring_q <= 1'b0;
`endif
    end else if (!IPIF_Bus2IP_resetn) begin
      mode_q <= 2'd0;
      len_q  <= DEPTH[15:0];
`ifdef STREAM_TO_BRAM_RING_EN
      ring_q <= 1'b0;
`endif
    end else begin
      if (wr_sel[0]) begin
        mode_q <= wd[2:1];
`ifdef STREAM_TO_BRAM_RING_EN
        ring_q <= wd[3];
`endif
      end
      if (wr_sel[1]) len_q <= wd[15:0];
    end
  end

  // Read-back mux for the selected register.
  always_comb begin
    rd_word = 32'b0;
    unique case (1'b1)
      rd_sel[0]: begin
`ifdef STREAM_TO_BRAM_RING_EN
        rd_word = {28'b0, ring_q, mode_q, 1'b0};
`else
        rd_word = {29'b0, mode_q, 1'b0};
`endif
      end
      rd_sel[1]: rd_word = {16'b0, len_q};
      rd_sel[2]: rd_word = {count_q[15:0], 14'b0, done_q, busy};
      rd_sel[3]: begin
`ifdef STREAM_TO_BRAM_RING_EN
        rd_word = {wrapped_q, 15'b0, last_q};
`else
        rd_word = 32'b0;
`endif
      end
      default: rd_word = 32'b0;
    endcase
  end

  // One-cycle acks with read data registered alongside.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      wr_ack_q <= |IPIF_Bus2IP_WrCE;
      rd_ack_q <= |IPIF_Bus2IP_RdCE;
      rdata_q  <= rd_word;
    end
  end

  assign IPIF_IP2Bus_Data  = C_S_AXI_DATA_WIDTH'(rdata_q);
  assign IPIF_IP2Bus_WrAck = wr_ack_q;
  assign IPIF_IP2Bus_RdAck = rd_ack_q;
  assign IPIF_IP2Bus_Error = 1'b0;

  // Orbit sync history and stream-ready flag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      orbit_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      orbit_q  <= fc_orbitSync;
      tready_q <= 1'b1;
    end
  end

  // Capture FSM next state: arm restarts from any state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
`ifdef STREAM_TO_BRAM_RING_EN
    wrapped_d = wrapped_q;
    last_d    = last_q;
`endif
    if (arm) begin
      state_d = (arm_mode == 2'd1) ? WAIT_TRIG : CAPTURE;
      count_d = 17'd0;
      done_d  = 1'b0;
`ifdef STREAM_TO_BRAM_RING_EN
      wrapped_d = 1'b0;
`endif
    end else begin
      if (wr_en) begin
        state_d = CAPTURE;
`ifdef STREAM_TO_BRAM_RING_EN
        last_d = count_q[15:0];
`endif
        if (count_q + 17'd1 >= len_eff) begin
          state_d = DONE;
          count_d = len_eff;
          done_d  = 1'b1;
`ifdef STREAM_TO_BRAM_RING_EN
          if (ring_q) begin
            state_d   = CAPTURE;
            count_d   = 17'd0;
            done_d    = 1'b0;
            wrapped_d = 1'b1;
          end
`endif
        end else begin
          count_d = count_q + 17'd1;
        end
      end
`ifdef STREAM_TO_BRAM_RING_EN
      if (stop && state_q == CAPTURE) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      count_q <= 17'd0;
      done_q  <= 1'b0;
`ifdef STREAM_TO_BRAM_RING_EN
      wrapped_q <= 1'b0;
      last_q    <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef STREAM_TO_BRAM_RING_EN
      wrapped_q <= wrapped_d;
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_to_bram.sv
// tb_stream_to_bram: directed vectors checked against a
// beat-counting model of the capture rules.
module tb_stream_to_bram;
  localparam int NV = 2100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn, ipif_rstn;
  logic [31:0] addr;
  logic        rnw, cs;
  logic [3:0]  be, rdce, wrce;
  logic [31:0] wdata, rdata;
  logic        wrack, rdack, err;
  logic        orbit;
  logic        b_clk, b_rst, bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_ADDR, bram_DIN;

  stream_to_bram_if s();

  stream_to_bram #(.MEM_DEPTH(2048)) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .IPIF_Bus2IP_resetn (ipif_rstn),
    .IPIF_Bus2IP_Addr   (addr),
    .IPIF_Bus2IP_RNW    (rnw),
    .IPIF_Bus2IP_BE     (be),
    .IPIF_Bus2IP_CS     (cs),
    .IPIF_Bus2IP_RdCE   (rdce),
    .IPIF_Bus2IP_WrCE   (wrce),
    .IPIF_Bus2IP_Data   (wdata),
    .IPIF_IP2Bus_Data   (rdata),
    .IPIF_IP2Bus_WrAck  (wrack),
    .IPIF_IP2Bus_RdAck  (rdack),
    .IPIF_IP2Bus_Error  (err),
    .fc_orbitSync       (orbit),
    .bram_CLK           (b_clk),
    .bram_RST           (b_rst),
    .bram_EN            (bram_EN),
    .bram_WE            (bram_WE),
    .bram_ADDR          (bram_ADDR),
    .bram_DIN           (bram_DIN),
    .data_stream        (s)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  bit          v_val[NV];
  logic [31:0] v_dat[NV];
  bit          v_orb[NV];
  bit          v_arm[NV];
  bit [1:0]    v_mode[NV];
  bit          v_rd[NV];
  bit          e_en[NV];
  logic [31:0] e_addr[NV];
  logic [31:0] e_stat[NV];

  logic [31:0] lg_addr[$];
  logic [31:0] lg_dat[$];
  int          lg_cyc[$];
  int          cur = 0;
  bit          chk_on = 0;

  task automatic clr_vec();
    for (int i = 0; i < NV; i++) begin
      v_val[i] = 0; v_dat[i] = 0; v_orb[i] = 0;
      v_arm[i] = 0; v_mode[i] = 0; v_rd[i] = 0;
    end
  endtask

  function automatic int last_arm(input int c);
    for (int k = c; k >= 0; k--)
      if (v_arm[k]) return k;
    return -1;
  endfunction

  // Cycle in which capture begins after an arm at cycle a.
  function automatic int trig(input int a, input int n);
    if (v_mode[a] == 2'd1) begin
      for (int e = a + 1; e < n; e++)
        if (v_orb[e] && !v_orb[e-1]) return e;
      return n;
    end
    return a + 1;
  endfunction

  function automatic int nval(input int lo, input int hi);
    int k = 0;
    for (int i = lo; i < hi; i++)
      if (v_val[i]) k++;
    return k;
  endfunction

  // A beat is stored iff it follows the trigger and fewer than L
  // beats have been stored since; its slot is that beat's rank.
  task automatic build_model(input int n, input int L);
    int a, t, k, w;
    bit d;
    for (int c = 0; c < n; c++) begin
      e_en[c] = 0; e_addr[c] = 0; e_stat[c] = 0;
      a = last_arm(c);
      if (a >= 0 && a < c) begin
        t = trig(a, n);
        if (c >= t && v_val[c]) begin
          k = nval(t, c);
          if (k < L) begin
            e_en[c] = 1;
            e_addr[c] = 32'(k * 4);
          end
        end
      end
      a = (c > 0) ? last_arm(c - 1) : -1;
      if (a >= 0) begin
        t = trig(a, n);
        w = (c > t) ? nval(t, c) : 0;
        if (w > L) w = L;
        d = (w == L);
        e_stat[c] = (32'(w) << 16) | {30'b0, d, !d};
      end
    end
  endtask

  task automatic run_vec(input int n);
    lg_addr.delete(); lg_dat.delete(); lg_cyc.delete();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      s.TVALID = v_val[c];
      s.TDATA  = v_dat[c];
      orbit    = v_orb[c];
      wrce  = v_arm[c] ? 4'b1000 : 4'b0000;
      wdata = v_arm[c] ? {29'b0, v_mode[c], 1'b1} : 32'b0;
      rdce  = v_rd[c] ? 4'b0010 : 4'b0000;
      cur = c;
      chk_on = 1;
    end
    @(posedge clk); #1;
    chk_on = 0;
    s.TVALID = 0; orbit = 0;
    wrce = 0; rdce = 0; wdata = 0;
  endtask

  // Per-cycle comparison of the BRAM port and IPIF acks.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("en", {31'b0, bram_EN}, {31'b0, e_en[cur]});
      chk("we", {28'b0, bram_WE}, e_en[cur] ? 32'hF : 32'h0);
      if (e_en[cur]) begin
        chk("addr", bram_ADDR, e_addr[cur]);
        chk("din", bram_DIN, v_dat[cur]);
      end
      if (cur > 0 && v_rd[cur-1]) begin
        chk("rdack", {31'b0, rdack}, 32'd1);
        chk("status", rdata, e_stat[cur-1]);
      end
      if (cur > 0 && v_arm[cur-1])
        chk("wrack", {31'b0, wrack}, 32'd1);
      if (bram_EN) begin
        lg_addr.push_back(bram_ADDR);
        lg_dat.push_back(bram_DIN);
        lg_cyc.push_back(cur);
      end
    end
  end

  task automatic wr_reg(input int i, input logic [31:0] d);
    @(posedge clk); #1;
    wrce = 4'b1000 >> i;
    wdata = d;
    @(posedge clk); #1;
    wrce = 0; wdata = 0;
    chk("wrack_reg", {31'b0, wrack}, 32'd1);
  endtask

  task automatic rd_reg(input int i, output logic [31:0] d);
    @(posedge clk); #1;
    rdce = 4'b1000 >> i;
    @(posedge clk); #1;
    rdce = 0;
    chk("rdack_reg", {31'b0, rdack}, 32'd1);
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    aresetn = 0; ipif_rstn = 0;
    addr = 0; rnw = 0; cs = 0; be = 0;
    rdce = 0; wrce = 0; wdata = 0; orbit = 0;
    s.TVALID = 0; s.TDATA = 0;
    #12;
    chk("rst_tready", {31'b0, s.TREADY}, 0);
    chk("rst_en", {31'b0, bram_EN}, 0);
    chk("rst_we", {28'b0, bram_WE}, 0);
    chk("rst_addr", bram_ADDR, 0);
    chk("rst_din", bram_DIN, 0);
    chk("rst_acks", {30'b0, wrack, rdack}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bram_rst", {31'b0, b_rst}, 1);
    @(posedge clk); #1;
    aresetn = 1; ipif_rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("tready", {31'b0, s.TREADY}, 1);
    chk("error", {31'b0, err}, 0);
    rd_reg(1, d);
    chk("len_default", d, 32'h800);

    // T1: immediate, len 4, six beats offered
    wr_reg(1, 4);
    clr_vec();
    v_arm[1] = 1;
    for (int c = 2; c < 8; c++) begin
      v_val[c] = 1;
      v_dat[c] = 32'hA0 + 32'(c - 2);
    end
    v_rd[10] = 1;
    build_model(12, 4);
    chk("model_t1", e_stat[10], 32'h0004_0002);
    run_vec(12);
    chk("t1_n", 32'(lg_addr.size()), 4);
    if (lg_addr.size() == 4) begin
      chk("t1_d0", lg_dat[0], 32'hA0);
      chk("t1_a3", lg_addr[3], 32'hC);
      chk("t1_d3", lg_dat[3], 32'hA3);
    end

    // T2: orbit trigger with edge at cycle 10
    clr_vec();
    v_arm[1] = 1; v_mode[1] = 2'd1;
    for (int c = 0; c < 20; c++) begin
      v_val[c] = 1;
      v_dat[c] = 32'hB00 + 32'(c);
      v_orb[c] = (c >= 10);
    end
    v_rd[5] = 1; v_rd[17] = 1;
    build_model(20, 4);
    chk("model_t2", e_stat[5], 32'h0000_0001);
    run_vec(20);
    chk("t2_n", 32'(lg_cyc.size()), 4);
    if (lg_cyc.size() > 0) begin
      chk("t2_cyc0", 32'(lg_cyc[0]), 10);
      chk("t2_a0", lg_addr[0], 32'h0);
    end

    // T3: gappy valid, len 3
    wr_reg(1, 3);
    clr_vec();
    v_arm[1] = 1;
    v_val[2] = 1; v_val[5] = 1; v_val[6] = 1;
    for (int c = 0; c < 12; c++) v_dat[c] = 32'hC0 + 32'(c);
    v_rd[9] = 1;
    build_model(12, 3);
    run_vec(12);
    chk("t3_n", 32'(lg_cyc.size()), 3);
    if (lg_cyc.size() == 3) begin
      chk("t3_cyc1", 32'(lg_cyc[1]), 5);
      chk("t3_a2", lg_addr[2], 32'h8);
    end

    // T4: re-arm at count 5
    wr_reg(1, 16);
    clr_vec();
    v_arm[1] = 1; v_arm[7] = 1;
    for (int c = 2; c < 20; c++) begin
      v_val[c] = 1;
      v_dat[c] = 32'hD0 + 32'(c);
    end
    v_rd[12] = 1;
    build_model(20, 16);
    chk("model_t4", e_stat[12], 32'h0004_0001);
    run_vec(20);
    chk("t4_n", 32'(lg_cyc.size()), 17);
    if (lg_cyc.size() > 5) begin
      chk("t4_cyc5", 32'(lg_cyc[5]), 8);
      chk("t4_a5", lg_addr[5], 32'h0);
    end

    // T5: len 0 -> full depth
    wr_reg(1, 0);
    clr_vec();
    v_arm[1] = 1;
    for (int c = 2; c < 2060; c++) begin
      v_val[c] = 1;
      v_dat[c] = 32'(c);
    end
    v_rd[2055] = 1;
    build_model(2060, 2048);
    chk("model_t5", e_stat[2055], 32'h0800_0002);
    run_vec(2060);
    chk("t5_n", 32'(lg_addr.size()), 2048);
    if (lg_addr.size() == 2048)
      chk("t5_last", lg_addr[2047], 32'h1FFC);

    // aresetn dropped mid-capture
    wr_reg(1, 8);
    @(posedge clk); #1;
    wrce = 4'b1000; wdata = 32'h1;
    s.TVALID = 1; s.TDATA = 32'h55;
    @(posedge clk); #1;
    wrce = 0; wdata = 0;
    #1 chk("en_cap", {31'b0, bram_EN}, 1);
    #1 aresetn = 0;
    #1 chk("en_rst", {31'b0, bram_EN}, 0);
    chk("tready_rst", {31'b0, s.TREADY}, 0);
    @(posedge clk); #1;
    s.TVALID = 0; aresetn = 1;
    repeat (2) @(posedge clk);
    rd_reg(2, d);
    chk("status_rst", d, 0);

    // register-bank reset only
    wr_reg(1, 7);
    rd_reg(1, d);
    chk("len_wr", d, 7);
    @(posedge clk); #1 ipif_rstn = 0;
    @(posedge clk); #1 ipif_rstn = 1;
    rd_reg(1, d);
    chk("len_ipif_rst", d, 32'h800);

    wr_reg(0, 32'h1A);
    rd_reg(0, d);
`ifdef STREAM_TO_BRAM_RING_EN
    chk("reg0", d, 32'hA);
`else
    chk("reg0", d, 32'h2);
    rd_reg(3, d);
    chk("reg3", d, 0);
`endif

`ifdef STREAM_TO_BRAM_RING_EN
    wr_reg(1, 2);
    wr_reg(0, 32'h9);
    for (int k = 0; k < 4; k++) begin
      s.TVALID = 1;
      s.TDATA = 32'hE0 + 32'(k);
      #2;
      chk("ring_en", {31'b0, bram_EN}, 1);
      chk("ring_addr", bram_ADDR, 32'((k % 2) * 4));
      @(posedge clk); #1;
    end
    s.TVALID = 0;
    rd_reg(3, d);
    chk("ring_reg3", d, 32'h8000_0001);
    wr_reg(0, 32'h18);
    rd_reg(2, d);
    chk("ring_stop_busy", {31'b0, d[0]}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
